// File: rtl/dma_multichannel_engine.sv
// N-channel DMA transfer engine: per-channel address/count/mode registers,
// fixed or rotating arbitration, and an IDLE/HOLD/XFER/UPD bus-cycle sequencer.
`timescale 1ns/1ps
module dma_multichannel_engine #(
  parameter int NCH = 4,
  parameter int AW  = 16,
  parameter int CW  = 16
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             wr_en,
  input  logic [$clog2(NCH)-1:0]           wr_ch,
  input  logic [1:0]                       wr_sel,
  input  logic [((AW > CW) ? AW : CW)-1:0] wr_data,
  input  logic [NCH-1:0]                   dreq,
  output logic                             hrq,
  input  logic                             hlda,
  output logic [NCH-1:0]                   dack,
  output logic [AW-1:0]                    addr,
  output logic                             mem_rd,
  output logic                             mem_wr,
  input  logic                             ready,
  output logic [NCH-1:0]                   tc,
  output logic [NCH-1:0]                   status_tc
);

  localparam int CHW = $clog2(NCH);
  localparam int DW  = (AW > CW) ? AW : CW;
  localparam logic [CHW:0] NCH_W = (CHW+1)'(NCH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] XFER = 2'd2;
  localparam logic [1:0] UPD  = 2'd3;

  logic [1:0]     state;
  logic [CHW-1:0] cur_ch;
  logic [CHW-1:0] prio_ptr;
  logic           rotate;

  logic [AW-1:0]  base_addr [NCH];
  logic [AW-1:0]  cur_addr  [NCH];
  logic [CW-1:0]  base_cnt  [NCH];
  logic [CW-1:0]  cur_cnt   [NCH];
  logic [4:0]     mode      [NCH];

  // Writes aimed at the channel in service are parked here until its grant ends.
  logic [2:0]     pend_valid;
  logic [DW-1:0]  pend_data [3];

  logic [NCH-1:0] elig;
  logic [NCH-1:0] ch_sel;
  logic [CHW-1:0] arb_base;
  logic [CHW-1:0] win_ch;
  logic           win_valid;
  logic           tc_hit;
  logic           upd_done;
  logic           grant_end;
  logic           defer_wr;
  logic           direct_wr;
  logic           in_xfer;
  logic [AW-1:0]  step_addr;
  logic [CHW:0]   ptr_inc;
  logic [CHW-1:0] ptr_next;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign elig[gi]   = mode[gi][0] & dreq[gi];
      assign ch_sel[gi] = (cur_ch == CHW'(gi));
    end
  endgenerate

  assign arb_base = rotate ? prio_ptr : '0;

  // Scan from lowest to highest priority so the highest-priority hit is kept.
  always_comb begin
    logic [CHW:0] idx;
    idx       = '0;
    win_valid = 1'b0;
    win_ch    = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = {1'b0, arb_base} + (CHW+1)'(k);
      if (idx >= NCH_W) begin
        idx = idx - NCH_W;
      end
      if (elig[idx[CHW-1:0]]) begin
        win_valid = 1'b1;
        win_ch    = idx[CHW-1:0];
      end
    end
  end

  assign tc_hit    = (cur_cnt[cur_ch] == '0);
  assign upd_done  = ~mode[cur_ch][4] | tc_hit;
  assign grant_end = ((state == UPD) && upd_done) ||
                     ((state == HOLD) && hlda && !dreq[cur_ch]);
  assign in_xfer   = (state == XFER);

  assign defer_wr  = wr_en && (wr_sel != 2'd3) && (wr_ch == cur_ch) &&
                     (state != IDLE) && !grant_end;
  assign direct_wr = wr_en && (wr_sel != 2'd3) && ({1'b0, wr_ch} < NCH_W) && !defer_wr;

  assign step_addr = mode[cur_ch][2] ? (cur_addr[cur_ch] - AW'(1))
                                     : (cur_addr[cur_ch] + AW'(1));
  assign ptr_inc   = {1'b0, cur_ch} + (CHW+1)'(1);
  assign ptr_next  = (ptr_inc >= NCH_W) ? '0 : ptr_inc[CHW-1:0];

  // Outputs decode straight from registered state so RESET clears them at once.
  assign hrq    = (state != IDLE);
  assign dack   = in_xfer ? ch_sel : '0;
  assign addr   = in_xfer ? cur_addr[cur_ch] : '0;
  assign mem_rd = in_xfer & ~mode[cur_ch][1];
  assign mem_wr = in_xfer &  mode[cur_ch][1];
  assign tc     = ((state == UPD) && tc_hit) ? ch_sel : '0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      cur_ch     <= '0;
      prio_ptr   <= '0;
      rotate     <= 1'b0;
      status_tc  <= '0;
      pend_valid <= '0;
      for (int c = 0; c < NCH; c++) begin
        base_addr[c] <= '0;
        cur_addr[c]  <= '0;
        base_cnt[c]  <= '0;
        cur_cnt[c]   <= '0;
        mode[c]      <= '0;
      end
      for (int s = 0; s < 3; s++) begin
        pend_data[s] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state  <= HOLD;
            cur_ch <= win_ch;
          end
        end
        HOLD: begin
          if (hlda) begin
            state <= dreq[cur_ch] ? XFER : IDLE;
          end
        end
        XFER: begin
          if (ready) begin
            state <= UPD;
          end
        end
        default: begin
          state <= upd_done ? IDLE : XFER;
        end
      endcase

      if ((state == UPD) && upd_done) begin
        prio_ptr <= ptr_next;
      end
      // A new priority setting restarts rotation with channel 0 on top.
      if (wr_en && (wr_sel == 2'd3)) begin
        rotate   <= wr_data[0];
        prio_ptr <= '0;
      end

      if (state == UPD) begin
        cur_addr[cur_ch] <= step_addr;
        cur_cnt[cur_ch]  <= cur_cnt[cur_ch] - CW'(1);
        if (tc_hit) begin
          status_tc[cur_ch] <= 1'b1;
          if (mode[cur_ch][3]) begin
            cur_addr[cur_ch] <= base_addr[cur_ch];
            cur_cnt[cur_ch]  <= base_cnt[cur_ch];
          end else begin
            mode[cur_ch][0] <= 1'b0;
          end
        end
      end

      // Register writes come after the UPD update so they override it.
      if (grant_end) begin
        pend_valid <= '0;
        if (pend_valid[0]) begin
          base_addr[cur_ch] <= pend_data[0][AW-1:0];
          cur_addr[cur_ch]  <= pend_data[0][AW-1:0];
        end
        if (pend_valid[1]) begin
          base_cnt[cur_ch] <= pend_data[1][CW-1:0];
          cur_cnt[cur_ch]  <= pend_data[1][CW-1:0];
        end
        if (pend_valid[2]) begin
          mode[cur_ch]      <= pend_data[2][4:0];
          status_tc[cur_ch] <= 1'b0;
        end
      end

      if (defer_wr) begin
        pend_valid[wr_sel] <= 1'b1;
        pend_data[wr_sel]  <= wr_data;
      end

      if (direct_wr) begin
        case (wr_sel)
          2'd0: begin
            base_addr[wr_ch] <= wr_data[AW-1:0];
            cur_addr[wr_ch]  <= wr_data[AW-1:0];
          end
          2'd1: begin
            base_cnt[wr_ch] <= wr_data[CW-1:0];
            cur_cnt[wr_ch]  <= wr_data[CW-1:0];
          end
          2'd2: begin
            mode[wr_ch]      <= wr_data[4:0];
            status_tc[wr_ch] <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_multichannel_engine.sv
// Scoreboard bench for dma_multichannel_engine: expected transfers are queued as
// channels are programmed and matched against transfers seen on dack/addr/strobes.
`timescale 1ns/1ps
module tb_dma_multichannel_engine;

  localparam int NCH = 4;
  localparam int AW  = 16;
  localparam int CW  = 16;
  localparam int DW  = 16;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           wr_en;
  logic [1:0]     wr_ch;
  logic [1:0]     wr_sel;
  logic [DW-1:0]  wr_data;
  logic [NCH-1:0] dreq;
  logic           hrq;
  logic           hlda;
  logic [NCH-1:0] dack;
  logic [AW-1:0]  addr;
  logic           mem_rd;
  logic           mem_wr;
  logic           ready;
  logic [NCH-1:0] tc;
  logic [NCH-1:0] status_tc;

  dma_multichannel_engine #(.NCH(NCH), .AW(AW), .CW(CW)) dut (
    .CLK(CLK), .RESET(RESET), .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel),
    .wr_data(wr_data), .dreq(dreq), .hrq(hrq), .hlda(hlda), .dack(dack),
    .addr(addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .ready(ready), .tc(tc),
    .status_tc(status_tc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int             ch;
    logic [AW-1:0]  addr;
    int             len;
    logic [NCH-1:0] tc;
    logic           rd;
    logic           wr;
    int             grant;
    logic           moved;
  } xfer_t;

  xfer_t obs[$];
  xfer_t exp_q[$];

  int n_cmp       = 0;
  int n_err       = 0;
  int grant_cnt   = 0;
  logic hrq_prev  = 1'b0;
  bit in_x        = 1'b0;
  bit hlda_en     = 1'b1;
  int wait_item   = -1;
  int wait_cycles = 0;
  int wait_left   = 0;

  function automatic int ch_of(logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic xfer_t mk(int ch, int a, int len, logic [NCH-1:0] t, logic w, int gr);
    xfer_t x;
    x.ch = ch; x.addr = a[AW-1:0]; x.len = len; x.tc = t;
    x.rd = ~w; x.wr = w; x.grant = gr; x.moved = 1'b0;
    return x;
  endfunction

  // One clock: observe the bus just after the edge, then play the arbiter and bus.
  task automatic tick();
    int li;
    @(posedge CLK); #1;
    if (hrq && !hrq_prev) grant_cnt++;
    hrq_prev = hrq;
    if (dack != '0) begin
      if (!in_x) begin
        obs.push_back(mk(ch_of(dack), 32'(addr), 1, '0, mem_wr, grant_cnt));
        li = obs.size() - 1;
        obs[li].rd = mem_rd;
        in_x = 1'b1;
        if (li == wait_item) wait_left = wait_cycles;
      end else begin
        li = obs.size() - 1;
        obs[li].len = obs[li].len + 1;
        if (addr !== obs[li].addr) obs[li].moved = 1'b1;
      end
    end else begin
      in_x = 1'b0;
    end
    if (tc != '0 && obs.size() > 0) begin
      li = obs.size() - 1;
      obs[li].tc = obs[li].tc | tc;
    end
    hlda = hrq & hlda_en;
    if (in_x && wait_left > 0) begin
      ready = 1'b0;
      wait_left--;
    end else begin
      ready = 1'b1;
    end
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic wr(int ch, int sel, int data);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_sel = 2'(sel); wr_data = 16'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++;
    if ({hrq, dack, addr, mem_rd, mem_wr, tc, status_tc} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", {hrq, dack, addr, mem_rd, mem_wr, tc, status_tc});
    end
    RESET = 1'b0;
    dreq = 4'b1111;
    run(5);
    n_cmp++;
    if ({hrq, dack} !== '0) begin
      n_err++;
      $display("FAIL reset_disabled: hrq/dack got %b want 0", {hrq, dack});
    end
    dreq = '0;
    run(2);
  endtask

  task automatic test_single();
    xfer_t e, o;
    int g;
    obs.delete(); g = grant_cnt;
    wr(1, 0, 32'h1000); wr(1, 1, 2); wr(1, 2, 32'h01);
    for (int i = 0; i < 3; i++)
      exp_q.push_back(mk(1, 32'h1000 + i, 1, (i == 2) ? 4'b0010 : 4'b0000, 1'b0, g + 1 + i));
    dreq = 4'b0010;
    run(30);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs.size() == 0) begin
        n_err++; $display("FAIL single_xfer: missing transfer, want ch%0d addr %h", e.ch, e.addr);
      end else begin
        o = obs.pop_front();
        $display("single: ch%0d addr %h len %0d tc %b rd %b wr %b grant %0d", o.ch, o.addr, o.len, o.tc, o.rd, o.wr, o.grant);
        if ({o.ch, o.addr, o.len, o.tc, o.rd, o.wr, o.grant, o.moved} !== {e.ch, e.addr, e.len, e.tc, e.rd, e.wr, e.grant, e.moved}) begin
          n_err++; $display("FAIL single_xfer: got ch%0d addr %h len %0d tc %b grant %0d, want ch%0d addr %h len %0d tc %b grant %0d",
                            o.ch, o.addr, o.len, o.tc, o.grant, e.ch, e.addr, e.len, e.tc, e.grant);
        end
      end
    end
    n_cmp++;
    if (obs.size() != 0 || hrq !== 1'b0) begin
      n_err++; $display("FAIL single_disabled: extra transfers %0d hrq %b, want 0 0", obs.size(), hrq);
    end
    n_cmp++;
    if (status_tc !== 4'b0010) begin
      n_err++; $display("FAIL single_status: got %b want 0010", status_tc);
    end
    dreq = '0;
    run(2);
  endtask

  task automatic test_block();
    xfer_t e, o;
    int g;
    obs.delete(); g = grant_cnt;
    wr(0, 0, 32'h0002); wr(0, 1, 3); wr(0, 2, 32'h15);
    wait_item = 1; wait_cycles = 2;
    exp_q.push_back(mk(0, 32'h0002, 1, 4'b0000, 1'b0, g + 1));
    exp_q.push_back(mk(0, 32'h0001, 3, 4'b0000, 1'b0, g + 1));
    exp_q.push_back(mk(0, 32'h0000, 1, 4'b0000, 1'b0, g + 1));
    exp_q.push_back(mk(0, 32'hFFFF, 1, 4'b0001, 1'b0, g + 1));
    dreq = 4'b0001;
    run(3);
    dreq = '0;
    run(25);
    wait_item = -1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs.size() == 0) begin
        n_err++; $display("FAIL block_xfer: missing transfer, want ch%0d addr %h", e.ch, e.addr);
      end else begin
        o = obs.pop_front();
        $display("block: ch%0d addr %h len %0d tc %b rd %b wr %b grant %0d", o.ch, o.addr, o.len, o.tc, o.rd, o.wr, o.grant);
        if ({o.ch, o.addr, o.len, o.tc, o.rd, o.wr, o.grant, o.moved} !== {e.ch, e.addr, e.len, e.tc, e.rd, e.wr, e.grant, e.moved}) begin
          n_err++; $display("FAIL block_xfer: got ch%0d addr %h len %0d tc %b grant %0d moved %b, want ch%0d addr %h len %0d tc %b grant %0d",
                            o.ch, o.addr, o.len, o.tc, o.grant, o.moved, e.ch, e.addr, e.len, e.tc, e.grant);
        end
      end
    end
    n_cmp++;
    if (obs.size() != 0 || status_tc[0] !== 1'b1) begin
      n_err++; $display("FAIL block_end: extra %0d status_tc %b, want 0 and bit0 set", obs.size(), status_tc);
    end
  endtask

  task automatic test_autoinit();
    xfer_t e, o;
    int g;
    obs.delete(); g = grant_cnt;
    wr(2, 0, 32'h0ABC); wr(2, 1, 0); wr(2, 2, 32'h09);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(mk(2, 32'h0ABC, 1, 4'b0100, 1'b0, g + 1 + i));
    dreq = 4'b0100;
    run(20);
    dreq = '0;
    run(6);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs.size() == 0) begin
        n_err++; $display("FAIL autoinit_xfer: missing transfer, want ch%0d addr %h", e.ch, e.addr);
      end else begin
        o = obs.pop_front();
        $display("autoinit: ch%0d addr %h len %0d tc %b rd %b wr %b grant %0d", o.ch, o.addr, o.len, o.tc, o.rd, o.wr, o.grant);
        if ({o.ch, o.addr, o.len, o.tc, o.rd, o.wr, o.grant, o.moved} !== {e.ch, e.addr, e.len, e.tc, e.rd, e.wr, e.grant, e.moved}) begin
          n_err++; $display("FAIL autoinit_xfer: got ch%0d addr %h tc %b grant %0d, want ch%0d addr %h tc %b grant %0d",
                            o.ch, o.addr, o.tc, o.grant, e.ch, e.addr, e.tc, e.grant);
        end
      end
    end
    obs.delete();
    n_cmp++;
    if (status_tc[2] !== 1'b1) begin
      n_err++; $display("FAIL autoinit_status: got %b want bit2 set", status_tc);
    end
    wr(2, 2, 0);
    n_cmp++;
    if (status_tc[2] !== 1'b0) begin
      n_err++; $display("FAIL mode_write_clears_status: got %b want bit2 clear", status_tc);
    end
  endtask

  task automatic test_withdraw();
    obs.delete();
    wr(3, 0, 32'h3000); wr(3, 1, 4); wr(3, 2, 32'h01);
    hlda_en = 1'b0;
    dreq = 4'b1000;
    run(3);
    n_cmp++;
    if (hrq !== 1'b1) begin
      n_err++; $display("FAIL withdraw_hold: hrq got %b want 1", hrq);
    end
    dreq = '0; hlda = 1'b1; hlda_en = 1'b1;
    tick();
    n_cmp++;
    if ({hrq, dack} !== '0) begin
      n_err++; $display("FAIL withdraw_release: hrq/dack got %b want 0", {hrq, dack});
    end
    run(6);
    n_cmp++;
    if (obs.size() != 0) begin
      n_err++; $display("FAIL withdraw_nodack: transfers got %0d want 0", obs.size());
    end
  endtask

  task automatic test_priority();
    xfer_t e, o;
    int g;
    obs.delete();
    for (int c = 0; c < NCH; c++) begin
      wr(c, 0, c * 32'h100); wr(c, 1, 32'hFF); wr(c, 2, 32'h01);
    end
    wr(0, 3, 0);
    g = grant_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, i, 1, 4'b0000, 1'b0, g + 1 + i));
    dreq = 4'b1111;
    run(18);
    dreq = '0;
    run(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs.size() == 0) begin
        n_err++; $display("FAIL fixed_prio: missing transfer, want ch%0d addr %h", e.ch, e.addr);
      end else begin
        o = obs.pop_front();
        $display("fixed: ch%0d addr %h len %0d grant %0d", o.ch, o.addr, o.len, o.grant);
        if ({o.ch, o.addr, o.len, o.tc, o.rd, o.wr, o.grant} !== {e.ch, e.addr, e.len, e.tc, e.rd, e.wr, e.grant}) begin
          n_err++; $display("FAIL fixed_prio: got ch%0d addr %h grant %0d, want ch%0d addr %h grant %0d",
                            o.ch, o.addr, o.grant, e.ch, e.addr, e.grant);
        end
      end
    end
    obs.delete();
    wr(0, 3, 1);
    wr(0, 0, 0);
    g = grant_cnt;
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(i, i * 32'h100, 1, 4'b0000, 1'b0, g + 1 + i));
    exp_q.push_back(mk(0, 1, 1, 4'b0000, 1'b0, g + 5));
    dreq = 4'b1111;
    run(22);
    dreq = '0;
    run(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs.size() == 0) begin
        n_err++; $display("FAIL rotate_prio: missing transfer, want ch%0d addr %h", e.ch, e.addr);
      end else begin
        o = obs.pop_front();
        $display("rotate: ch%0d addr %h len %0d grant %0d", o.ch, o.addr, o.len, o.grant);
        if ({o.ch, o.addr, o.len, o.tc, o.rd, o.wr, o.grant} !== {e.ch, e.addr, e.len, e.tc, e.rd, e.wr, e.grant}) begin
          n_err++; $display("FAIL rotate_prio: got ch%0d addr %h grant %0d, want ch%0d addr %h grant %0d",
                            o.ch, o.addr, o.grant, e.ch, e.addr, e.grant);
        end
      end
    end
    obs.delete();
  endtask

  task automatic test_reset_mid();
    xfer_t e, o;
    int g;
    obs.delete();
    wr(0, 0, 32'h4000); wr(0, 1, 5); wr(0, 2, 32'h11);
    wait_item = 0; wait_cycles = 20;
    dreq = 4'b0001;
    run(4);
    n_cmp++;
    if (dack !== 4'b0001) begin
      n_err++; $display("FAIL reset_mid_pre: dack got %b want 0001", dack);
    end
    #2 RESET = 1'b1;
    #1;
    n_cmp++;
    if ({hrq, dack, addr, mem_rd, mem_wr, tc, status_tc} !== '0) begin
      n_err++; $display("FAIL reset_async: outputs got %h want 0", {hrq, dack, addr, mem_rd, mem_wr, tc, status_tc});
    end
    wait_item = -1; wait_left = 0; ready = 1'b1; hlda = 1'b0;
    @(posedge CLK);
    #2 RESET = 1'b0;
    obs.delete(); g = grant_cnt;
    dreq = 4'b1111;
    run(10);
    n_cmp++;
    if (grant_cnt != g || obs.size() != 0) begin
      n_err++; $display("FAIL reset_nodma: grants %0d transfers %0d, want 0 0", grant_cnt - g, obs.size());
    end
    dreq = 4'b0001;
    wr(0, 0, 32'h0055); wr(0, 1, 0); wr(0, 2, 32'h03);
    exp_q.push_back(mk(0, 32'h0055, 1, 4'b0001, 1'b1, g + 1));
    run(10);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_cmp++;
      if (obs.size() == 0) begin
        n_err++; $display("FAIL reprogram_xfer: missing transfer, want ch%0d addr %h", e.ch, e.addr);
      end else begin
        o = obs.pop_front();
        $display("reprogram: ch%0d addr %h len %0d tc %b rd %b wr %b grant %0d", o.ch, o.addr, o.len, o.tc, o.rd, o.wr, o.grant);
        if ({o.ch, o.addr, o.len, o.tc, o.rd, o.wr, o.grant} !== {e.ch, e.addr, e.len, e.tc, e.rd, e.wr, e.grant}) begin
          n_err++; $display("FAIL reprogram_xfer: got ch%0d addr %h tc %b rd %b wr %b, want ch%0d addr %h tc %b rd %b wr %b",
                            o.ch, o.addr, o.tc, o.rd, o.wr, e.ch, e.addr, e.tc, e.rd, e.wr);
        end
      end
    end
    n_cmp++;
    if (obs.size() != 0) begin
      n_err++; $display("FAIL reprogram_once: extra transfers %0d want 0", obs.size());
    end
    dreq = '0;
  endtask

  initial begin
    RESET = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_sel = '0; wr_data = '0;
    dreq = '0; hlda = 1'b0; ready = 1'b1;
    test_reset();
    test_single();
    test_block();
    test_autoinit();
    test_withdraw();
    test_priority();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_multichannel_engine.md
# dma_multichannel_engine

Parametrised successor to the four-channel 8237A-style controller: an N-channel DMA transfer engine with configurable address and count widths, per-channel modes and selectable fixed or rotating priority. It sits between the peripherals' DREQ/DACK lines and the system bus arbiter (HRQ/HLDA). It drives one address, and one read or write strobe, per transfer cycle. Channel registers are loaded through a flat write port from the CPU-side register decoder.

## Interface
- NCH, 4: number of channels (2..8).
- AW, 16: address width.
- CW, 16: transfer-count width; a programmed count of N moves N+1 items.
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- wr_en  in  1  register write strobe.
- wr_ch  in  $clog2(NCH)  target channel.
- wr_sel  in  2  0 = base address, 1 = base count, 2 = mode, 3 = priority control (wr_ch ignored).
- wr_data  in  max(AW,CW)  write data; LSBs used.
- dreq  in  NCH  level-sensitive peripheral requests.
- hrq  out  1  bus hold request.
- hlda  in  1  bus hold acknowledge.
- dack  out  NCH  one-hot transfer acknowledge.
- addr  out  AW  transfer address.
- mem_rd, mem_wr  out  1  transfer strobes.
- ready  in  1  bus ready; low inserts wait states.
- tc  out  NCH  one-cycle terminal-count pulse, per channel.
- status_tc  out  NCH  sticky TC flags, cleared by any mode write to that channel.

## Operation
- Per-channel mode bits: [0] enable, [1] direction (0 = read memory, 1 = write memory), [2] decrement, [3] autoinit, [4] block mode (0 = single).
- Priority control: bit 0 selects rotating (1) or fixed (0) priority.
- Writing the base address or base count also loads the current address or current count.
- A channel is eligible when its enable bit and its dreq are both 1.
- Fixed priority: channel 0 is highest.
- Rotating priority: the channel just serviced becomes lowest priority after its grant completes.
- State machine IDLE -> HOLD -> XFER -> UPD:
  - IDLE: if any channel is eligible, assert hrq, latch the winning channel, go to HOLD.
  - HOLD: wait for hlda = 1. If the latched channel's dreq has dropped at that point, deassert hrq and return to IDLE.
  - XFER: drive addr = current address, the dack bit, and mem_rd or mem_wr. Stay in XFER while ready = 0.
  - UPD:
    - Address moves ±1, modulo 2^AW (wrap-around is legal). Count decrements.
    - When count was 0 before the decrement, that is terminal count: pulse tc, set status_tc.
    - At terminal count with autoinit, reload current address and count from the base values and keep the channel enabled. Without autoinit, clear the enable bit.
    - Single mode, or terminal count: release hrq and go to IDLE.
    - Block mode, not at terminal count: return to XFER with no re-arbitration, regardless of dreq.
- A register write to the channel in service takes effect after the grant ends. Writes to other channels apply immediately.
- If a register write and UPD hit the same channel in the same cycle, the write wins.

## Timing
- Reset values:
  - State IDLE; hrq, dack, mem_rd, mem_wr, tc = 0; addr = 0.
  - All channel registers 0, so all channels are disabled; fixed priority.
- RESET asserted mid-transfer drops all outputs asynchronously. No partial update is committed.
- hrq rises in the cycle after an eligible dreq is sampled.
- The first XFER cycle is the cycle after hlda is sampled high.
- XFER lasts 1 + (number of ready-low cycles). UPD lasts 1 cycle.
- dack and the strobes are high only in XFER. addr holds for all of XFER.
- Block-mode throughput: one item per 2 cycles with ready = 1.
- tc pulses during the UPD cycle.
- hrq falls in the cycle after the final UPD.

## Test plan
- Single-mode read: ch1 base 0x1000, count 2, mode 0x01; dreq[1] = 1, hlda returned 1 cycle after hrq. Required: 3 separate grants at addr 0x1000, 0x1001, 0x1002; tc[1] pulses on the 3rd; ch1 disabled afterwards.
- Block mode with decrement and wait states: ch0 base 0x0002, count 3, mode 0x15; ready low for 2 cycles on the 2nd item. Required: addr 0x0002, 0x0001, 0x0000, 0xFFFF under one hrq; the 2nd XFER lasts 3 cycles.
- Autoinit: ch2 count 0, mode 0x09, dreq held high. Required: tc[2] pulses on every transfer; addr repeats the base value; the channel stays enabled.
- Priority: dreq = 4'b1111, all channels enabled, single mode. Fixed: grant order 0, 0, 0… Rotating: grant order 0, 1, 2, 3, 0.
- Withdrawn request: dreq[3] drops while in HOLD. Required: no dack, and hrq falls in the cycle after hlda is sampled.
- RESET pulsed mid-XFER. Required: all outputs 0 immediately; after release, no transfer occurs until the channels are reprogrammed.
